// File: rtl/exme_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exme_pkg
//  Description : Shared types and helpers for the EX/MEM stage register.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package exme_pkg;

    localparam int EXME_XLEN = 32;
    localparam int EXME_RAW  = 5;

    // Result-select encoding seen by the write-back mux
    localparam logic [1:0] RSLT_ALU = 2'b00;
    localparam logic [1:0] RSLT_MEM = 2'b01;
    localparam logic [1:0] RSLT_PC4 = 2'b10;
    localparam logic [1:0] RSLT_UJ  = 2'b11;

    typedef struct packed {
        logic       regWrt;
        logic       memWrt;
        logic [1:0] rsltSrc;
    } exme_ctrl_t;

    typedef struct packed {
        logic [EXME_XLEN-1:0] aluRslt;
        logic [EXME_XLEN-1:0] wrtD;
        logic [EXME_XLEN-1:0] pc4;
        logic [EXME_XLEN-1:0] ujWrtBck;
        logic [EXME_RAW-1:0]  rd;
    } exme_data_t;

    localparam int EXME_CTRL_W = $bits(exme_ctrl_t);

    // A bubble must never write the register file or memory
    function automatic exme_ctrl_t gate_ctrl(input exme_ctrl_t c, input logic vld);
        exme_ctrl_t g;
        g        = c;
        g.regWrt = c.regWrt & vld;
        g.memWrt = c.memWrt & vld;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry
//  Description : One payload register with valid bit; clear beats load.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry
    import exme_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         w_load;

    // A held beat is frozen even if a stray load arrives
    assign w_load = load_i && !hold_i;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (w_load) begin
            vld_d  = 1'b1;
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;

endmodule
`default_nettype wire

// File: rtl/exme_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : exme_pipe_reg
//  Description : EX/MEM stage register with valid/ready, flush, optional skid
//                entry and a saturating stall counter.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module exme_pipe_reg
    import exme_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            inVld,
    output logic            inRdy,
    input  logic            regWrte,
    input  logic            memWrte,
    input  logic [1:0]      rsltSrce,
    input  logic [XLEN-1:0] aluRslte,
    input  logic [XLEN-1:0] wrtDe,
    input  logic [XLEN-1:0] pc4e,
    input  logic [XLEN-1:0] ujWrtBcke,
    input  logic [RAW-1:0]  rde,
    output logic            outVld,
    input  logic            outRdy,
    output logic            regWrtm,
    output logic            memWrtm,
    output logic [1:0]      rsltSrcm,
    output logic [XLEN-1:0] aluRsltm,
    output logic [XLEN-1:0] wrtDm,
    output logic [XLEN-1:0] pc4m,
    output logic [XLEN-1:0] ujWrtBckm,
    output logic [RAW-1:0]  rdm,
    output logic [CNTW-1:0] stallCnt
);

    localparam int CW = EXME_CTRL_W;
    localparam int DW = 4 * XLEN + RAW;
    localparam int PW = CW + DW;

    exme_ctrl_t      w_ctrl_in;
    exme_ctrl_t      w_ctrl_out;
    exme_ctrl_t      w_ctrl_gated;
    logic [PW-1:0]   w_in_beat;
    logic [PW-1:0]   w_main_q;
    logic            w_main_vld;
    logic            w_in_rdy;
    logic            w_out_xfer;

    assign w_ctrl_in.regWrt  = regWrte;
    assign w_ctrl_in.memWrt  = memWrte;
    assign w_ctrl_in.rsltSrc = rsltSrce;
    assign w_in_beat         = {w_ctrl_in, aluRslte, wrtDe, pc4e, ujWrtBcke, rde};
    assign w_out_xfer        = w_main_vld && outRdy;

    generate
        if (SKID != 0) begin : g_skid
            logic          w_skid_vld;
            logic [PW-1:0] w_skid_q;
            logic          w_in_xfer;
            logic          w_skid_promote;
            logic          w_main_load;
            logic          w_main_clr;
            logic [PW-1:0] w_main_src;
            logic          w_skid_load;
            logic          w_skid_clr;

            // Ready depends only on the skid flop, so it is a registered signal
            assign w_in_rdy       = !w_skid_vld;
            assign w_in_xfer      = inVld && w_in_rdy && !flush;
            assign w_skid_promote = w_out_xfer && w_skid_vld;

            assign w_main_load = !flush &&
                                 (w_skid_promote || (w_in_xfer && (!w_main_vld || w_out_xfer)));
            assign w_main_src  = w_skid_promote ? w_skid_q : w_in_beat;
            assign w_main_clr  = flush || (w_out_xfer && !w_main_load);

            // Skid catches a beat when main stays occupied after this edge
            assign w_skid_load = w_in_xfer && w_main_vld && (!w_out_xfer || w_skid_vld);
            assign w_skid_clr  = flush || (w_skid_promote && !w_skid_load);

            pipe_entry #(.W(PW)) u_main (
                .clk    (clk),
                .rstn   (rstn),
                .load_i (w_main_load),
                .clr_i  (w_main_clr),
                .hold_i (w_main_vld && !outRdy),
                .d_i    (w_main_src),
                .vld_o  (w_main_vld),
                .q_o    (w_main_q)
            );

            pipe_entry #(.W(PW)) u_skid (
                .clk    (clk),
                .rstn   (rstn),
                .load_i (w_skid_load),
                .clr_i  (w_skid_clr),
                .hold_i (w_skid_vld && !w_out_xfer),
                .d_i    (w_in_beat),
                .vld_o  (w_skid_vld),
                .q_o    (w_skid_q)
            );
        end else begin : g_noskid
            logic w_in_xfer;

            assign w_in_rdy  = !w_main_vld || outRdy;
            assign w_in_xfer = inVld && w_in_rdy && !flush;

            pipe_entry #(.W(PW)) u_main (
                .clk    (clk),
                .rstn   (rstn),
                .load_i (w_in_xfer),
                .clr_i  (flush || (w_out_xfer && !w_in_xfer)),
                .hold_i (w_main_vld && !outRdy),
                .d_i    (w_in_beat),
                .vld_o  (w_main_vld),
                .q_o    (w_main_q)
            );
        end
    endgenerate

    assign w_ctrl_out   = w_main_q[PW-1 -: CW];
    assign w_ctrl_gated = gate_ctrl(w_ctrl_out, w_main_vld);

    assign inRdy     = w_in_rdy;
    assign outVld    = w_main_vld;
    assign regWrtm   = w_ctrl_gated.regWrt;
    assign memWrtm   = w_ctrl_gated.memWrt;
    assign rsltSrcm  = w_ctrl_gated.rsltSrc;
    assign aluRsltm  = w_main_q[DW-1 -: XLEN];
    assign wrtDm     = w_main_q[DW-XLEN-1 -: XLEN];
    assign pc4m      = w_main_q[DW-2*XLEN-1 -: XLEN];
    assign ujWrtBckm = w_main_q[DW-3*XLEN-1 -: XLEN];
    assign rdm       = w_main_q[RAW-1:0];

    logic [CNTW-1:0] stall_q;
    logic [CNTW-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (w_main_vld && !outRdy && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stallCnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_exme_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exme_pipe_reg
//  Description : Bench for exme_pipe_reg (SKID=1/CNTW=16 and SKID=0/CNTW=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exme_pipe_reg;

    typedef struct packed {
        logic        regWrt;
        logic        memWrt;
        logic [1:0]  rsltSrc;
        logic [31:0] alu;
        logic [31:0] wrtD;
        logic [31:0] pc4;
        logic [31:0] uj;
        logic [4:0]  rd;
    } beat_t;

    logic  clk    = 1'b0;
    logic  rstn   = 1'b1;
    logic  flush  = 1'b0;
    logic  inVld  = 1'b0;
    logic  outRdy = 1'b0;
    beat_t bin    = '0;

    logic        a_inRdy, a_outVld, a_regWrtm, a_memWrtm;
    logic [1:0]  a_rsltSrcm;
    logic [31:0] a_alu, a_wrtD, a_pc4, a_uj;
    logic [4:0]  a_rd;
    logic [15:0] a_cnt;
    logic        b_inRdy, b_outVld, b_regWrtm, b_memWrtm;
    logic [1:0]  b_rsltSrcm;
    logic [31:0] b_alu, b_wrtD, b_pc4, b_uj;
    logic [4:0]  b_rd;
    logic [3:0]  b_cnt;
    beat_t       a_obs, b_obs;

    assign a_obs = {a_regWrtm, a_memWrtm, a_rsltSrcm, a_alu, a_wrtD, a_pc4, a_uj, a_rd};
    assign b_obs = {b_regWrtm, b_memWrtm, b_rsltSrcm, b_alu, b_wrtD, b_pc4, b_uj, b_rd};

    always #5 clk = ~clk;

    exme_pipe_reg #(.XLEN(32), .RAW(5), .SKID(1), .CNTW(16)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .inVld(inVld), .inRdy(a_inRdy),
        .regWrte(bin.regWrt), .memWrte(bin.memWrt), .rsltSrce(bin.rsltSrc),
        .aluRslte(bin.alu), .wrtDe(bin.wrtD), .pc4e(bin.pc4), .ujWrtBcke(bin.uj), .rde(bin.rd),
        .outVld(a_outVld), .outRdy(outRdy), .regWrtm(a_regWrtm), .memWrtm(a_memWrtm),
        .rsltSrcm(a_rsltSrcm), .aluRsltm(a_alu), .wrtDm(a_wrtD), .pc4m(a_pc4),
        .ujWrtBckm(a_uj), .rdm(a_rd), .stallCnt(a_cnt)
    );

    exme_pipe_reg #(.XLEN(32), .RAW(5), .SKID(0), .CNTW(4)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush), .inVld(inVld), .inRdy(b_inRdy),
        .regWrte(bin.regWrt), .memWrte(bin.memWrt), .rsltSrce(bin.rsltSrc),
        .aluRslte(bin.alu), .wrtDe(bin.wrtD), .pc4e(bin.pc4), .ujWrtBcke(bin.uj), .rde(bin.rd),
        .outVld(b_outVld), .outRdy(outRdy), .regWrtm(b_regWrtm), .memWrtm(b_memWrtm),
        .rsltSrcm(b_rsltSrcm), .aluRsltm(b_alu), .wrtDm(b_wrtD), .pc4m(b_pc4),
        .ujWrtBckm(b_uj), .rdm(b_rd), .stallCnt(b_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: index 0 is a 2-deep FIFO (SKID=1), index 1 a 1-deep one (SKID=0)
    beat_t mq[2][2];
    int    mcnt[2];
    beat_t mdisp[2];
    int    mstall[2];
    int    smax[2] = '{65535, 15};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_rdy(input int k);
        if (k == 0) return (mcnt[0] < 2);
        return (mcnt[1] == 0) || outRdy;
    endfunction

    function automatic beat_t exp_out(input int k);
        beat_t e;
        e = mdisp[k];
        if (mcnt[k] == 0) begin
            e.regWrt = 1'b0;
            e.memWrt = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]   = 0;
            mdisp[k]  = '0;
            mstall[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic rdy;
            rdy = model_rdy(k);
            if (mcnt[k] > 0 && !outRdy && mstall[k] < smax[k]) mstall[k]++;
            if (flush) begin
                mcnt[k] = 0;
            end else begin
                if (mcnt[k] > 0 && outRdy) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (inVld && rdy) begin
                    mq[k][mcnt[k]] = bin;
                    mcnt[k]++;
                end
            end
            if (mcnt[k] > 0) mdisp[k] = mq[k][0];
        end
    endtask

    task automatic check_all();
        chk("a_outVld", a_outVld, mcnt[0] > 0);
        chk("a_inRdy",  a_inRdy,  model_rdy(0));
        chk("a_payload", a_obs, exp_out(0));
        chk("a_stallCnt", a_cnt, mstall[0]);
        chk("b_outVld", b_outVld, mcnt[1] > 0);
        chk("b_inRdy",  b_inRdy,  model_rdy(1));
        chk("b_payload", b_obs, exp_out(1));
        chk("b_stallCnt", b_cnt, mstall[1]);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        b.regWrt  = 1'($urandom);
        b.memWrt  = 1'($urandom);
        b.rsltSrc = 2'($urandom);
        b.alu     = $urandom;
        b.wrtD    = $urandom;
        b.pc4     = $urandom;
        b.uj      = $urandom;
        b.rd      = 5'($urandom);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rstn = 1'b0;
        #1 check_all();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // First beat after reset
        bin = '0; bin.alu = 32'h0000_1234; bin.rd = 5'd5; bin.regWrt = 1'b1;
        inVld = 1'b1; outRdy = 1'b1;
        cyc();
        chk("first_vld", a_outVld, 1'b1);
        chk("first_alu", a_alu, 32'h0000_1234);
        chk("first_rd",  a_rd, 5'd5);
        inVld = 1'b0;
        cyc();

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) begin
            bin = rnd_beat(); bin.pc4 = 32'(4 * (i + 1));
            inVld = 1'b1;
            cyc();
            chk("stream_pc4", a_pc4, 32'(4 * (i + 1)));
        end
        inVld = 1'b0;
        cyc();

        // Back-pressure fills main and skid
        outRdy = 1'b0; inVld = 1'b1;
        bin = rnd_beat(); bin.alu = 32'hA; cyc();
        bin = rnd_beat(); bin.alu = 32'hB; cyc();
        bin = rnd_beat(); bin.alu = 32'hC; cyc();
        cyc();
        chk("bp_inRdy", a_inRdy, 1'b0);
        chk("bp_stall", a_cnt, 16'd3);
        chk("bp_head",  a_alu, 32'hA);
        inVld = 1'b0; outRdy = 1'b1;
        cyc();
        chk("bp_second_vld", a_outVld, 1'b1);
        chk("bp_second", a_alu, 32'hB);
        cyc();
        cyc();

        // Flush with both entries full and a write beat incoming
        outRdy = 1'b0; inVld = 1'b1;
        bin = rnd_beat(); cyc();
        bin = rnd_beat(); cyc();
        bin = rnd_beat(); bin.memWrt = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0; inVld = 1'b0;
        chk("flush_vld", a_outVld, 1'b0);
        chk("flush_memWrt", a_memWrtm, 1'b0);
        chk("flush_inRdy", a_inRdy, 1'b1);
        outRdy = 1'b1;
        repeat (3) cyc();

        // Bubble gating keeps rd but kills regWrt
        bin = rnd_beat(); bin.regWrt = 1'b1; bin.rd = 5'h1B;
        inVld = 1'b1;
        cyc();
        inVld = 1'b0;
        cyc();
        chk("bubble_regWrt", a_regWrtm, 1'b0);
        chk("bubble_rd", a_rd, 5'h1B);

        // Long stall saturates the 4-bit counter
        bin = rnd_beat(); inVld = 1'b1; outRdy = 1'b0;
        cyc();
        inVld = 1'b0;
        repeat (20) cyc();
        chk("sat_cnt", b_cnt, 4'hF);

        // Reset in the middle of a stall
        #2 rstn = 1'b0;
        model_reset();
        #1 check_all();
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        bin = rnd_beat(); bin.alu = 32'h55; inVld = 1'b1; outRdy = 1'b1;
        cyc();
        chk("post_rst_vld", a_outVld, 1'b1);
        chk("post_rst_alu", a_alu, 32'h55);
        inVld = 1'b0;
        cyc();

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            bin    = rnd_beat();
            inVld  = ($urandom_range(0, 3) != 0);
            outRdy = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            cyc();
        end
        flush = 1'b0; inVld = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exme_pipe_reg.md
Name: exme_pipe_reg

Overview:
- Parametrised successor to the fixed EX/MEM register. Carries the execute-stage control and data bundle into the memory stage.
- Adds a valid/ready handshake, stall back-pressure, flush (bubble insertion), an optional skid entry and a saturating stall counter.
- Sits between the ALU/branch unit and the data-memory interface; the same module also serves as a generic in-order stage register.

Parameters:
- XLEN, 32, width of aluRslt, wrtD, pc4 and ujWrtBck fields.
- RAW, 5, register-address width of rd.
- SKID, 1, 1 = two-entry (main + skid) with registered inRdy; 0 = single entry with combinational inRdy.
- CNTW, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held and incoming beats.
- inVld  in  1  execute stage presents a beat.
- inRdy  out  1  stage can accept a beat.
- regWrte, memWrte  in  1 each  control inputs.
- rsltSrce  in  2  result-select input.
- aluRslte, wrtDe, pc4e, ujWrtBcke  in  XLEN each  data inputs.
- rde  in  RAW  destination register.
- outVld  out  1  memory-stage beat valid.
- outRdy  in  1  memory stage accepts the beat.
- regWrtm, memWrtm  out  1 each  gated control outputs.
- rsltSrcm  out  2  result-select output.
- aluRsltm, wrtDm, pc4m, ujWrtBckm  out  XLEN each  data outputs.
- rdm  out  RAW  destination register output.
- stallCnt  out  CNTW  saturating count of cycles with outVld && !outRdy.

Behaviour:
- Reset: asynchronous assert on rstn low; release synchronous to clk. All outputs, including stallCnt, reset to 0, except inRdy = 1. Both entries are invalid after reset.
- Transfers: in-transfer = inVld && inRdy; out-transfer = outVld && outRdy. Latency is 1 cycle from in-transfer to outVld when the stage is empty.
- SKID=0:
  - inRdy = !outVld || outRdy, combinational.
  - Main entry loads on in-transfer, else clears valid on out-transfer.
- SKID=1:
  - inRdy = !skidVld, registered.
  - Main empty, or main draining this cycle: beat goes to main.
  - Main full and not draining: beat goes to skid.
  - On out-transfer with skid valid: skid moves to main and skid clears.
  - Simultaneous skid drain and new input: the new beat goes to skid.
  - Order is preserved in all cases; no beat is dropped or duplicated.
- Payload holding:
  - A held beat's payload never changes while outVld && !outRdy.
  - When outVld = 0, regWrtm and memWrtm are forced to 0. Data fields hold their last value.
- Flush:
  - Highest priority. Next cycle main and skid are both invalid and outVld = 0.
  - A beat presented in the flush cycle is discarded even if inRdy = 1.
  - inRdy = 1 the cycle after flush.
  - stallCnt is not cleared by flush.
- Flush and reset mid-stall: both leave no residual beat; the next accepted beat appears as the first outVld.
- stallCnt: increments on each cycle with outVld && !outRdy. Saturates at all-ones and does not wrap. Clears only on reset.

Decomposition:
- Shared package exme_pkg:
  - exme_ctrl_t struct: regWrt, memWrt, rsltSrc[1:0].
  - exme_data_t struct, parametrised via XLEN/RAW localparams: aluRslt, wrtD, pc4, ujWrtBck, rd.
  - Result-select encoding constants.
- Sub-module pipe_entry: one payload register with valid, load, clear and hold controls, instantiated twice (main, skid) under generate on SKID.

Test Plan:
- Reset: rstn low mid-traffic -> all outputs 0 and inRdy = 1 immediately. First beat after release (aluRslte = 0x0000_1234, rde = 5) appears with outVld = 1 one cycle after in-transfer.
- Streaming: outRdy = 1, 8 back-to-back beats with pc4e = 4, 8, ... 32 -> pc4m sequence identical, one per cycle, with no bubbles.
- Back-pressure (SKID=1): outRdy = 0 for 3 cycles while inVld = 1.
  - inRdy falls after 2 beats are held; stallCnt = 3.
  - On outRdy = 1, both beats are delivered in order (0xA, then 0xB) with no loss.
- Flush: flush while main and skid are full and inVld = 1 carries memWrte = 1 -> next cycle outVld = 0 and memWrtm = 0; the flushed beats never appear.
- Bubble gating: inVld = 0 after a beat with regWrte = 1 is consumed -> regWrtm = 0 while rdm holds its last value.
- Saturation: CNTW = 4, hold outRdy = 0 for 20 cycles -> stallCnt stops at 15 and does not wrap.
